// File: rtl/decoder_seq_if.sv
// decoder_seq_if: code handshake in, one-hot strobe out, for decoder_seq.
interface decoder_seq_if;
  logic        en;
  logic [0:3]  a;
  logic        a_valid;
  logic        a_ready;
  logic [0:15] d;
  logic        d_valid;
  logic        busy;
  modport slave (input en, a, a_valid, output a_ready, d, d_valid, busy);
  modport master (output en, a, a_valid, input a_ready, d, d_valid, busy);
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq: registered 4-to-16 one-hot decoder; each strobe is held HOLD cycles
// and followed by a one-cycle gap, with a one-entry pending register for the next code.
module decoder_seq #(
  parameter int HOLD = 4
) (
  input logic         clk,
  input logic         rst,
  decoder_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  state_t      r_state, w_state;
  logic [0:15] r_d, w_d;
  logic        r_dv, w_dv;
  logic [7:0]  r_cnt, w_cnt;
  logic [0:3]  r_pc, w_pc;
  logic        r_pv, w_pv;
  logic        w_acc;
  // a[0] carries weight 1, so the index is the code with bit order reversed
  function automatic logic [0:15] onehot(input logic [0:3] c);
    logic [0:15] o;
    o = '0;
    o[{c[3], c[2], c[1], c[0]}] = 1'b1;
    return o;
  endfunction
  assign bus.a_ready = bus.en & ~r_pv;
  assign w_acc       = bus.a_valid & bus.a_ready;
  assign bus.d       = r_d;
  assign bus.d_valid = r_dv;
  assign bus.busy    = (r_state != IDLE) | r_pv;
  always_comb begin
    w_state = r_state;
    w_d     = r_d;
    w_dv    = r_dv;
    w_cnt   = r_cnt;
    w_pc    = r_pc;
    w_pv    = r_pv;
    if (!bus.en) begin
      w_state = IDLE;
      w_d     = '0;
      w_dv    = 1'b0;
      w_cnt   = '0;
      w_pv    = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (r_pv | w_acc) begin
          w_state = ACTIVE;
          w_d     = onehot(r_pv ? r_pc : bus.a);
          w_dv    = 1'b1;
          w_cnt   = 8'(HOLD - 1);
          w_pv    = 1'b0;
        end
        ACTIVE: begin
          if (w_acc) begin
            w_pc = bus.a;
            w_pv = 1'b1;
          end
          if (r_cnt != 8'd0) w_cnt = r_cnt - 8'd1;
          else begin
            w_state = GAP;
            w_d     = '0;
            w_dv    = 1'b0;
          end
        end
        GAP: if (r_pv) begin
          w_state = ACTIVE;
          w_d     = onehot(r_pc);
          w_dv    = 1'b1;
          w_cnt   = 8'(HOLD - 1);
          w_pv    = 1'b0;
        end else begin
          w_state = IDLE;
          if (w_acc) begin
            w_pc = bus.a;
            w_pv = 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_dv    <= 1'b0;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_pv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_d     <= w_d;
      r_dv    <= w_dv;
      r_cnt   <= w_cnt;
      r_pc    <= w_pc;
      r_pv    <= w_pv;
    end
  end
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: two decoders (HOLD=4 and HOLD=1) against a cycle model of the strobe rules.
module tb_decoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        en[2];
  logic [0:3]  a[2];
  logic        av[2];
  logic [0:15] o_d[2];
  logic        o_dv[2], o_ar[2], o_busy[2];
  decoder_seq_if b0();
  decoder_seq_if b1();
  assign b0.en = en[0];
  assign b0.a = a[0];
  assign b0.a_valid = av[0];
  assign b1.en = en[1];
  assign b1.a = a[1];
  assign b1.a_valid = av[1];
  assign o_d[0] = b0.d;
  assign o_dv[0] = b0.d_valid;
  assign o_ar[0] = b0.a_ready;
  assign o_busy[0] = b0.busy;
  assign o_d[1] = b1.d;
  assign o_dv[1] = b1.d_valid;
  assign o_ar[1] = b1.a_ready;
  assign o_busy[1] = b1.busy;
  decoder_seq #(.HOLD(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  decoder_seq #(.HOLD(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;
  int hold[2] = '{4, 1};
  int m_ph[2] = '{0, 0};
  int m_left[2] = '{0, 0};
  int m_cur[2] = '{0, 0};
  int m_pend[2] = '{-1, -1};
  bit m_acc[2] = '{0, 0};
  localparam logic [0:15] D0  = 16'b1000_0000_0000_0000;
  localparam logic [0:15] D1  = 16'b0100_0000_0000_0000;
  localparam logic [0:15] D2  = 16'b0010_0000_0000_0000;
  localparam logic [0:15] D3  = 16'b0001_0000_0000_0000;
  localparam logic [0:15] D5  = 16'b0000_0100_0000_0000;
  localparam logic [0:15] D11 = 16'b0000_0000_0001_0000;
  localparam logic [0:15] D12 = 16'b0000_0000_0000_1000;
  function automatic int code_of(logic [0:3] x);
    return int'(x[0]) + 2 * int'(x[1]) + 4 * int'(x[2]) + 8 * int'(x[3]);
  endfunction
  function automatic logic [0:3] to_a(int c);
    logic [0:3] r;
    for (int j = 0; j < 4; j++) r[j] = c[j];
    return r;
  endfunction
  function automatic int encode(logic [0:15] x);
    int r = 0;
    for (int j = 0; j < 16; j++) if (x[j]) r = j;
    return r;
  endfunction
  function automatic logic [0:15] exp_d(int i);
    return (m_ph[i] == 1) ? 16'h8000 >> m_cur[i] : 16'h0000;
  endfunction
  // phase 0 idle, 1 strobe high (m_left cycles still to show), 2 gap
  task automatic model_step(int i);
    bit acc;
    acc = av[i] && en[i] && m_pend[i] < 0;
    m_acc[i] = acc;
    if (!en[i]) begin
      m_ph[i] = 0;
      m_pend[i] = -1;
    end else if (m_ph[i] == 0) begin
      if (m_pend[i] >= 0) begin
        m_ph[i] = 1; m_cur[i] = m_pend[i]; m_left[i] = hold[i]; m_pend[i] = -1;
      end else if (acc) begin
        m_ph[i] = 1; m_cur[i] = code_of(a[i]); m_left[i] = hold[i];
      end
    end else if (m_ph[i] == 1) begin
      if (acc) m_pend[i] = code_of(a[i]);
      if (m_left[i] > 1) m_left[i]--;
      else m_ph[i] = 2;
    end else begin
      if (m_pend[i] >= 0) begin
        m_ph[i] = 1; m_cur[i] = m_pend[i]; m_left[i] = hold[i]; m_pend[i] = -1;
      end else begin
        m_ph[i] = 0;
        if (acc) m_pend[i] = code_of(a[i]);
      end
    end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 0; m_pend[i] = -1; m_acc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("d", i, 32'(o_d[i]), 32'(exp_d(i)));
        chk("d_valid", i, 32'(o_dv[i]), 32'(m_ph[i] == 1));
        chk("busy", i, 32'(o_busy[i]), 32'(m_ph[i] != 0 || m_pend[i] >= 0));
        chk("a_ready", i, 32'(o_ar[i]), 32'(en[i] && m_pend[i] < 0));
        chk("popcount", i, 32'($countones(o_d[i])), 32'(o_dv[i]));
        if (o_dv[i]) chk("encode", i, 32'(encode(o_d[i])), 32'(m_cur[i]));
      end
    end
  end
  task automatic step();
    @(negedge clk);
    #2;
  endtask
  int seq[2];
  initial begin
    en = '{1'b1, 1'b1};
    av = '{1'b0, 1'b0};
    a = '{4'b0000, 4'b0000};
    repeat (2) step();
    rst = 1'b0;
    step();
    chk_on = 1;
    chk("rst_d", 0, 32'(o_d[0]), 32'h0);
    chk("rst_busy", 0, 32'(o_busy[0]), 32'h0);
    chk("rst_dv", 1, 32'(o_dv[1]), 32'h0);
    a[0] = 4'b1010; av[0] = 1'b1;
    step();
    av[0] = 1'b0;
    chk("t1_d5", 0, 32'(o_d[0]), 32'(D5));
    repeat (3) step();
    chk("t1_d5_last", 0, 32'(o_d[0]), 32'(D5));
    step();
    chk("t1_gap", 0, 32'(o_d[0]), 32'h0);
    chk("t1_gap_busy", 0, 32'(o_busy[0]), 32'h1);
    step();
    chk("t1_idle", 0, 32'(o_busy[0]), 32'h0);
    a[0] = 4'b1100; av[0] = 1'b1;
    step();
    a[0] = 4'b0011;
    step();
    av[0] = 1'b0;
    chk("t2_ready_low", 0, 32'(o_ar[0]), 32'h0);
    chk("t2_d3", 0, 32'(o_d[0]), 32'(D3));
    repeat (2) step();
    chk("t2_d3_last", 0, 32'(o_d[0]), 32'(D3));
    step();
    chk("t2_gap", 0, 32'(o_d[0]), 32'h0);
    chk("t2_gap_ready", 0, 32'(o_ar[0]), 32'h0);
    step();
    chk("t2_d12", 0, 32'(o_d[0]), 32'(D12));
    chk("t2_ready_back", 0, 32'(o_ar[0]), 32'h1);
    repeat (3) step();
    chk("t2_d12_last", 0, 32'(o_d[0]), 32'(D12));
    repeat (2) step();
    chk("t2_idle", 0, 32'(o_busy[0]), 32'h0);
    a[0] = 4'b1110; av[0] = 1'b1;
    step();
    a[0] = 4'b1001;
    step();
    av[0] = 1'b0; en[0] = 1'b0;
    #1 chk("t4_ready_comb", 0, 32'(o_ar[0]), 32'h0);
    step();
    chk("t4_d", 0, 32'(o_d[0]), 32'h0);
    chk("t4_busy", 0, 32'(o_busy[0]), 32'h0);
    en[0] = 1'b1;
    step();
    chk("t4_stays_idle", 0, 32'(o_busy[0]), 32'h0);
    a[0] = 4'b0100; av[0] = 1'b1;
    step();
    av[0] = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    chk("t5_d_async", 0, 32'(o_d[0]), 32'h0);
    chk("t5_dv_async", 0, 32'(o_dv[0]), 32'h0);
    chk("t5_busy_async", 0, 32'(o_busy[0]), 32'h0);
    step();
    rst = 1'b0;
    step();
    a[0] = 4'b1101; av[0] = 1'b1;
    step();
    av[0] = 1'b0;
    chk("t5_d11", 0, 32'(o_d[0]), 32'(D11));
    repeat (6) step();
    a[1] = 4'b0000; av[1] = 1'b1;
    step();
    a[1] = 4'b1000;
    chk("t6_d0", 1, 32'(o_d[1]), 32'(D0));
    step();
    a[1] = 4'b0100;
    chk("t6_gap0", 1, 32'(o_d[1]), 32'h0);
    chk("t6_gap0_ready", 1, 32'(o_ar[1]), 32'h0);
    step();
    chk("t6_d1", 1, 32'(o_d[1]), 32'(D1));
    step();
    av[1] = 1'b0;
    chk("t6_gap1", 1, 32'(o_d[1]), 32'h0);
    step();
    chk("t6_d2", 1, 32'(o_d[1]), 32'(D2));
    step();
    chk("t6_gap2", 1, 32'(o_d[1]), 32'h0);
    step();
    chk("t6_idle", 1, 32'(o_busy[1]), 32'h0);
    seq = '{0, 0};
    repeat (130) begin
      for (int i = 0; i < 2; i++) begin
        if (!av[i] || m_acc[i]) begin
          if (seq[i] < 16) begin
            a[i] = to_a(seq[i]); av[i] = 1'b1; seq[i]++;
          end else av[i] = 1'b0;
        end
      end
      step();
    end
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        en[i] = $urandom_range(0, 24) != 0;
        if (!av[i] || m_acc[i]) begin
          av[i] = $urandom_range(0, 2) != 0;
          a[i] = 4'($urandom);
        end
      end
      step();
    end
    en = '{1'b1, 1'b1};
    av = '{1'b0, 1'b0};
    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
